// File: rtl/ram_fifo_ctrl_if.sv
// Stream and RAM-port bundle for ram_fifo_ctrl.
// The controller attaches through the slave modport. The environment (producer,
// consumer and the RAM) attaches through the master modport.
interface ram_fifo_ctrl_if #(
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 3
);
    logic                 in_valid;
    logic                 in_ready;
    logic [DATAWIDTH-1:0] in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [DATAWIDTH-1:0] out_data;
    logic                 ram_en_w_n;
    logic [ADDRWIDTH-1:0] ram_addr_w;
    logic [DATAWIDTH-1:0] ram_data_w;
    logic                 ram_en_r_n;
    logic [ADDRWIDTH-1:0] ram_addr_r;
    logic [DATAWIDTH-1:0] ram_data_r;

    modport master (
        output in_valid, in_data, out_ready, ram_data_r,
        input  in_ready, out_valid, out_data,
               ram_en_w_n, ram_addr_w, ram_data_w, ram_en_r_n, ram_addr_r
    );

    modport slave (
        input  in_valid, in_data, out_ready, ram_data_r,
        output in_ready, out_valid, out_data,
               ram_en_w_n, ram_addr_w, ram_data_w, ram_en_r_n, ram_addr_r
    );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: turns an external flop RAM (registered write, combinational read)
// into a valid/ready FIFO with a registered show-ahead output stage.
// Optional feature: define FIFO_CTRL_FLUSH_EN to add a synchronous flush input.
module ram_fifo_ctrl #(
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
`ifdef FIFO_CTRL_FLUSH_EN
    input  logic                 flush,
`endif
    ram_fifo_ctrl_if.slave       bus,
    output logic [ADDRWIDTH:0]   count,
    output logic                 full,
    output logic                 empty
);
    localparam int               DEPTH    = 1 << ADDRWIDTH;
    localparam logic [ADDRWIDTH:0] OCC_FULL = (ADDRWIDTH+1)'(DEPTH);

    // Output stage FSM: EMPTY means out_data is stale, HOLD means it is the head entry.
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    logic [ADDRWIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDRWIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDRWIDTH:0]   occ_q, occ_d;
    logic [0:0]           state_q, state_d;
    logic [DATAWIDTH-1:0] out_data_q, out_data_d;
    logic                 flush_w;
    logic                 in_ready_w;
    logic                 push;
    logic                 load;

`ifdef FIFO_CTRL_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    // Handshake decode. The load is gated by committed occupancy only, so a word just
    // being written is never read in the same cycle.
    always_comb begin
        in_ready_w = (occ_q != OCC_FULL) & ~flush_w;
        push       = bus.in_valid & in_ready_w;
        load       = (occ_q != '0) & ((state_q == ST_EMPTY) | bus.out_ready) & ~flush_w;
    end

    assign bus.in_ready   = in_ready_w;
    assign bus.ram_en_w_n = ~push;
    assign bus.ram_addr_w = wr_ptr_q;
    assign bus.ram_data_w = bus.in_data;
    assign bus.ram_en_r_n = ~load;
    assign bus.ram_addr_r = rd_ptr_q;
    assign bus.out_valid  = (state_q == ST_HOLD);
    assign bus.out_data   = out_data_q;

    assign count = occ_q + {{ADDRWIDTH{1'b0}}, bus.out_valid};
    assign full  = (occ_q == OCC_FULL);
    assign empty = (count == '0);

    // Next-state for pointers, occupancy and the output stage; flush overrides everything.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        state_d    = state_q;
        out_data_d = out_data_q;
        if (flush_w) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
            state_d  = ST_EMPTY;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (load) begin
                rd_ptr_d   = rd_ptr_q + 1'b1;
                out_data_d = bus.ram_data_r;
                state_d    = ST_HOLD;
            end else if ((state_q == ST_HOLD) && bus.out_ready) begin
                state_d = ST_EMPTY;
            end
            occ_d = occ_q + {{ADDRWIDTH{1'b0}}, push} - {{ADDRWIDTH{1'b0}}, load};
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            state_q    <= ST_EMPTY;
            out_data_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            state_q    <= state_d;
            out_data_q <= out_data_d;
        end
    end
endmodule
